// File: rtl/mem_stage.sv
// MEM pipeline stage: runs one handshaked data-memory access per load/store,
// stalls upstream while waiting, and writes the MEM/WB register with timeout bubbles.
module mem_stage #(
  parameter int N       = 24,
  parameter int BW      = 64,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [BW-1:0] exMem,
  output logic [N-1:0]  memAddr,
  output logic [N-1:0]  memWdata,
  output logic          memWe,
  output logic          memReq,
  input  logic          memReady,
  input  logic [N-1:0]  memRdata,
  output logic          stall,
  output logic          memErr,
  output logic [N-1:0]  wbData,
  output logic [3:0]    wbRc,
  output logic          wbRegWrite,
  output logic          wbValid,
  output logic [N-1:0]  fwdData,
  output logic [3:0]    fwdRc,
  output logic          fwdRegWrite
);

  localparam int ALU_LO  = N + 10;
  localparam int ALU_HI  = 2 * N + 9;
  localparam int MW_BIT  = N + 6;
  localparam int MTR_BIT = N + 5;
  localparam int RW_BIT  = N + 4;
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [7:0]   r_wait;
  logic [N-1:0] r_alu;
  logic [N-1:0] r_sd;
  logic [3:0]   r_rc;
  logic         r_mw;
  logic         r_mtr;
  logic         r_rw;
  logic         r_mem_err;
  logic [N-1:0] r_wb_data;
  logic [3:0]   r_wb_rc;
  logic         r_wb_rw;
  logic         r_wb_valid;

  logic [N-1:0] w_alu;
  logic [N-1:0] w_sd;
  logic [3:0]   w_rc;
  logic         w_mw;
  logic         w_mtr;
  logic         w_rw;
  logic         w_mem_op;
  logic         w_access;
  logic         w_launch;
  logic         w_done;
  logic         w_timeout;
  logic         w_unused;

  assign w_alu    = exMem[ALU_HI:ALU_LO];
  assign w_sd     = exMem[N-1:0];
  assign w_rc     = exMem[N+3:N];
  assign w_mw     = exMem[MW_BIT];
  assign w_mtr    = exMem[MTR_BIT];
  assign w_rw     = exMem[RW_BIT];
  assign w_mem_op = w_mw | w_mtr;
  assign w_access = (r_state == S_ACCESS);
  // Opcode/type and condition flags are consumed elsewhere in the pipeline.
  assign w_unused = ^{exMem[BW-1:ALU_HI+1], exMem[N+9:N+7]};

  assign fwdData     = w_alu;
  assign fwdRc       = w_rc;
  assign fwdRegWrite = w_rw & ~w_mtr;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_next    = r_state;
    w_launch  = 1'b0;
    w_done    = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en && w_mem_op) begin
          w_launch = 1'b1;
          w_next   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (memReady) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else if (r_wait == WAIT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Reset is synchronous, so the bus is also masked combinationally while rst is high.
  assign memReq   = w_access & ~rst;
  assign memAddr  = memReq ? r_alu : '0;
  assign memWdata = memReq ? r_sd : '0;
  assign memWe    = memReq & r_mw;
  assign stall    = ~rst & (w_launch | (w_access & ~memReady));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_wait    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mem_err <= w_timeout;
      if (w_launch)
        r_wait <= '0;
      else if (w_access && !memReady && r_wait != '1)
        r_wait <= r_wait + 8'd1;
    end
  end

  // NOTE: the latched bundle is datapath only and is never observed outside ACCESS, so it has no reset.
  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_alu <= w_alu;
      r_sd  <= w_sd;
      r_rc  <= w_rc;
      r_mw  <= w_mw;
      r_mtr <= w_mtr;
      r_rw  <= w_rw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_data  <= '0;
      r_wb_rc    <= '0;
      r_wb_rw    <= 1'b0;
      r_wb_valid <= 1'b0;
    end else if (w_done) begin
      r_wb_data  <= (r_mtr && !r_mw) ? memRdata : r_alu;
      r_wb_rc    <= r_rc;
      r_wb_rw    <= r_rw & ~r_mw;
      r_wb_valid <= 1'b1;
    end else if (w_timeout) begin
      r_wb_data  <= '0;
      r_wb_rc    <= '0;
      r_wb_rw    <= 1'b0;
      r_wb_valid <= 1'b0;
    end else if (!w_access && en && !w_mem_op) begin
      r_wb_data  <= w_alu;
      r_wb_rc    <= w_rc;
      r_wb_rw    <= w_rw;
      r_wb_valid <= 1'b1;
    end
  end

  assign memErr     = r_mem_err;
  assign wbData     = r_wb_data;
  assign wbRc       = r_wb_rc;
  assign wbRegWrite = r_wb_rw;
  assign wbValid    = r_wb_valid;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios then randomized transactions,
// checked against a transaction-level expectation of the MEM/WB register and bus.
module tb_mem_stage;

  localparam int N       = 24;
  localparam int BW      = 64;
  localparam int TIMEOUT = 16;

  logic          clk;
  logic          rst;
  logic          en;
  logic [BW-1:0] exMem;
  logic [N-1:0]  memAddr;
  logic [N-1:0]  memWdata;
  logic          memWe;
  logic          memReq;
  logic          memReady;
  logic [N-1:0]  memRdata;
  logic          stall;
  logic          memErr;
  logic [N-1:0]  wbData;
  logic [3:0]    wbRc;
  logic          wbRegWrite;
  logic          wbValid;
  logic [N-1:0]  fwdData;
  logic [3:0]    fwdRc;
  logic          fwdRegWrite;

  mem_stage #(.N(N), .BW(BW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .en(en), .exMem(exMem),
    .memAddr(memAddr), .memWdata(memWdata), .memWe(memWe), .memReq(memReq),
    .memReady(memReady), .memRdata(memRdata),
    .stall(stall), .memErr(memErr),
    .wbData(wbData), .wbRc(wbRc), .wbRegWrite(wbRegWrite), .wbValid(wbValid),
    .fwdData(fwdData), .fwdRc(fwdRc), .fwdRegWrite(fwdRegWrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  // Expected MEM/WB contents, updated once per completed transaction.
  logic [N-1:0] e_data;
  logic [3:0]   e_rc;
  logic         e_rw;
  logic         e_valid;
  logic         e_rc_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input logic [N-1:0] alu, input logic [3:0] rc,
                                       input logic rw, input logic mw, input logic mtr,
                                       input logic [N-1:0] sd);
    logic [1:0] op_type;
    logic [3:0] op_code;
    logic [2:0] flags;
    op_type = 2'($urandom);
    op_code = 4'($urandom);
    flags   = 3'($urandom);
    return {op_type, op_code, alu, flags, mw, mtr, rw, rc, sd};
  endfunction

  task automatic check_wb(input string ctx);
    chk({ctx, ".wbData"},     32'(wbData),     32'(e_data));
    chk({ctx, ".wbRegWrite"}, 32'(wbRegWrite), 32'(e_rw));
    chk({ctx, ".wbValid"},    32'(wbValid),    32'(e_valid));
    if (e_rc_known)
      chk({ctx, ".wbRc"}, 32'(wbRc), 32'(e_rc));
  endtask

  // Non-memory instruction presented for one cycle in IDLE.
  task automatic alu_op(input logic [N-1:0] alu, input logic [3:0] rc,
                        input logic rw, input logic en_i);
    exMem    = mk(alu, rc, rw, 1'b0, 1'b0, N'($urandom));
    en       = en_i;
    memReady = 1'($urandom);
    memRdata = N'($urandom);
    @(negedge clk);
    chk("alu.stall",       32'(stall),       32'(0));
    chk("alu.memReq",      32'(memReq),      32'(0));
    chk("alu.memErr",      32'(memErr),      32'(0));
    chk("alu.fwdData",     32'(fwdData),     32'(alu));
    chk("alu.fwdRc",       32'(fwdRc),       32'(rc));
    chk("alu.fwdRegWrite", 32'(fwdRegWrite), 32'(rw));
    if (en_i) begin
      e_data = alu; e_rc = rc; e_rw = rw; e_valid = 1'b1; e_rc_known = 1'b1;
    end
    @(posedge clk); #1;
    check_wb("alu");
  endtask

  // Memory instruction: ready arrives on ACCESS cycle d (d==0: never, so it times out),
  // followed by one cycle with en=0 and another memory op waiting upstream.
  task automatic mem_op(input logic [N-1:0] alu, input logic [3:0] rc, input logic rw,
                        input logic mw, input logic mtr, input logic [N-1:0] sd,
                        input int d, input logic [N-1:0] rdata);
    int limit;
    exMem    = mk(alu, rc, rw, mw, mtr, sd);
    en       = 1'b1;
    memReady = 1'($urandom);
    memRdata = N'($urandom);
    @(negedge clk);
    chk("launch.stall",       32'(stall),       32'(1));
    chk("launch.memReq",      32'(memReq),      32'(0));
    chk("launch.fwdRegWrite", 32'(fwdRegWrite), 32'(rw & ~mtr));
    @(posedge clk); #1;
    limit = (d == 0) ? TIMEOUT : d;
    for (int k = 1; k <= limit; k++) begin
      exMem    = {$urandom, $urandom};
      en       = 1'($urandom);
      memReady = (k == d);
      memRdata = (k == d) ? rdata : N'($urandom);
      @(negedge clk);
      chk("acc.memReq",   32'(memReq),   32'(1));
      chk("acc.memAddr",  32'(memAddr),  32'(alu));
      chk("acc.memWdata", 32'(memWdata), 32'(sd));
      chk("acc.memWe",    32'(memWe),    32'(mw));
      chk("acc.stall",    32'(stall),    32'(k != d));
      chk("acc.memErr",   32'(memErr),   32'(0));
      @(posedge clk); #1;
    end
    if (d != 0) begin
      e_data = (mtr && !mw) ? rdata : alu;
      e_rc = rc; e_rw = rw & ~mw; e_valid = 1'b1; e_rc_known = 1'b1;
    end else begin
      e_data = '0; e_rw = 1'b0; e_valid = 1'b0; e_rc_known = 1'b0;
    end
    check_wb(d == 0 ? "timeout" : "done");
    exMem    = mk(N'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'($urandom), N'($urandom));
    en       = 1'b0;
    memReady = 1'($urandom);
    @(negedge clk);
    chk("after.memReq", 32'(memReq), 32'(0));
    chk("after.stall",  32'(stall),  32'(0));
    chk("after.memErr", 32'(memErr), 32'(d == 0));
    @(posedge clk); #1;
    check_wb("hold");
    chk("hold.memErr", 32'(memErr), 32'(0));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    e_data = '0; e_rc = '0; e_rw = 1'b0; e_valid = 1'b0; e_rc_known = 1'b1;

    // Reset, with a memory op and ready present to prove reset dominates.
    rst      = 1'b1;
    en       = 1'b1;
    exMem    = mk(24'h000100, 4'd3, 1'b1, 1'b0, 1'b1, 24'h0);
    memReady = 1'b1;
    memRdata = 24'hFFFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.stall",    32'(stall),    32'(0));
    chk("rst.memReq",   32'(memReq),   32'(0));
    chk("rst.memWe",    32'(memWe),    32'(0));
    chk("rst.memAddr",  32'(memAddr),  32'(0));
    chk("rst.memWdata", 32'(memWdata), 32'(0));
    chk("rst.memErr",   32'(memErr),   32'(0));
    check_wb("rst");
    @(posedge clk); #1;
    en  = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    check_wb("post_rst");

    // ALU pass-through.
    alu_op(24'h00ABCD, 4'd5, 1'b1, 1'b1);
    // en=0 holds MEM/WB.
    alu_op(24'h777777, 4'd9, 1'b0, 1'b0);
    // Load with ready on the 3rd ACCESS cycle.
    mem_op(24'h000100, 4'd2, 1'b1, 1'b0, 1'b1, 24'h0, 3, 24'h123456);
    // Store with immediate ready.
    mem_op(24'h000200, 4'd7, 1'b1, 1'b1, 1'b0, 24'h0000FF, 1, 24'h0BAD00);
    // Timeout on a load.
    mem_op(24'h000300, 4'd4, 1'b1, 1'b0, 1'b1, 24'h0, 0, 24'h0);
    // Both flags: treated as a store; the trailing en=0 cycle must not launch.
    mem_op(24'h000400, 4'd6, 1'b1, 1'b1, 1'b1, 24'h00CAFE, 2, 24'h654321);

    // Reset on the 2nd ACCESS cycle aborts the access.
    exMem    = mk(24'h000500, 4'd8, 1'b1, 1'b0, 1'b1, 24'h0);
    en       = 1'b1;
    memReady = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort.acc1.memReq", 32'(memReq), 32'(1));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort.rst.memReq", 32'(memReq), 32'(0));
    chk("abort.rst.stall",  32'(stall),  32'(0));
    @(posedge clk); #1;
    rst      = 1'b0;
    en       = 1'b0;
    memReady = 1'b1;
    memRdata = 24'h5A5A5A;
    e_data = '0; e_rc = '0; e_rw = 1'b0; e_valid = 1'b0; e_rc_known = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("abort.memReq",   32'(memReq),   32'(0));
      chk("abort.memAddr",  32'(memAddr),  32'(0));
      chk("abort.memWe",    32'(memWe),    32'(0));
      chk("abort.memWdata", 32'(memWdata), 32'(0));
      chk("abort.stall",    32'(stall),    32'(0));
      chk("abort.memErr",   32'(memErr),   32'(0));
      check_wb("abort");
      @(posedge clk); #1;
    end

    // Randomized transaction mix.
    for (int t = 0; t < 48; t++) begin
      int kind;
      int d;
      kind = int'($urandom_range(0, 3));
      d    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      case (kind)
        0: alu_op(N'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
        1: mem_op(N'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'b1, N'($urandom), d, N'($urandom));
        2: mem_op(N'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b0, N'($urandom), d, N'($urandom));
        default: mem_op(N'($urandom), 4'($urandom), 1'($urandom), 1'b1, 1'b1, N'($urandom), d, N'($urandom));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
